// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared types and the golden result function for the instruction register.
// Contents:
//   operand_t / result_t        signed 32 / signed 64 data types
//   opcode_t                    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD, POW
//   address_t                   5-bit register index
//   instruction_t               {opc, op_a, op_b, res}
//   seq_state_t                 read-sequencer FSM states
//   calc_expected()             expected result per opcode, used by the checker and the bench
package instr_register_pkg;

   localparam int ADDR_W = 5;

   typedef logic signed [31:0] operand_t;
   typedef logic signed [63:0] result_t;
   typedef logic [ADDR_W-1:0]  address_t;

   typedef enum logic [3:0] {
      ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD, POW
   } opcode_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
      result_t  res;
   } instruction_t;

   typedef enum logic [1:0] {IDLE, FETCH, PRESENT, FINISH} seq_state_t;

   localparam instruction_t INSTR_RESET = '{opc: ZERO, op_a: '0, op_b: '0, res: '0};

   // Operands are sign-extended to 64 bits before any arithmetic. POW uses
   // square-and-multiply over the exponent bits so it stays synthesizable;
   // the product wraps modulo 2**64 exactly like repeated multiplication.
   function automatic result_t calc_expected(opcode_t opc, operand_t a, operand_t b);
      result_t ra;
      result_t rb;
      result_t p;
      result_t base;
      ra = a;
      rb = b;
      p = 64'sd1;
      base = ra;
      for (int i = 0; i < 31; i++) begin
         if (b[i]) p = p * base;
         base = base * base;
      end
      case (opc)
         ZERO:    return '0;
         PASSA:   return ra;
         PASSB:   return rb;
         ADD:     return ra + rb;
         SUB:     return ra - rb;
         MULT:    return ra * rb;
         DIV:     return (rb == 0) ? '0 : ra / rb;
         MOD:     return (rb == 0) ? '0 : ra % rb;
         POW:     return (rb < 0) ? '0 : p;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/instr_result_check.sv
// instr_result_check: combinational comparison of a captured entry against its recomputed result.
// Ports:
//   instr_i     captured instruction entry
//   mismatch_o  1 when res differs from the expected result or the opcode encoding is undefined
module instr_result_check
   import instr_register_pkg::*;
(
   input  instruction_t instr_i,
   output logic         mismatch_o
);

   // Encodings above POW have no defined result and always count as a mismatch.
   assign mismatch_o = (instr_i.opc > POW) ? 1'b1
                     : (calc_expected(instr_i.opc, instr_i.op_a, instr_i.op_b) != instr_i.res);

endmodule

// File: rtl/instr_read_seq.sv
// instr_read_seq: walks a window of instruction-register entries and streams them out with a result check.
// Optional feature macro: INSTR_CHECK_EN (defined: result checker present; undefined: mismatch/err_count stay 0).
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               one-cycle request to begin a sequence (ignored while busy or count out of 1..DEPTH)
//   first_ptr, count    first entry and number of entries to read
//   instruction_word    register entry for read_pointer (combinational)
//   read_pointer        entry currently addressed
//   out_valid/out_ready output stream handshake
//   out_instr, out_ptr  captured entry and its index
//   mismatch            captured entry failed the result check
//   busy, done          sequence in progress / one-cycle pulse after the last handshake
//   err_count           saturating mismatch count since reset
module instr_read_seq
   import instr_register_pkg::*;
#(
   parameter int DEPTH     = 32,
   parameter int ERR_CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  address_t             first_ptr,
   input  logic [5:0]           count,
   input  instruction_t         instruction_word,
   output address_t             read_pointer,
   output logic                 out_valid,
   input  logic                 out_ready,
   output instruction_t         out_instr,
   output address_t             out_ptr,
   output logic                 mismatch,
   output logic                 busy,
   output logic                 done,
   output logic [ERR_CNT_W-1:0] err_count
);

   seq_state_t           state_q, state_d;
   address_t             ptr_q, ptr_d;
   address_t             out_ptr_q, out_ptr_d;
   logic [5:0]           rem_q, rem_d;
   logic                 valid_q, valid_d;
   logic                 mm_q, mm_d;
   logic                 busy_q, busy_d;
   instruction_t         instr_q, instr_d;
   logic [ERR_CNT_W-1:0] err_q, err_d;
   logic                 chk;
   logic                 start_ok;
   address_t             ptr_inc;

`ifdef INSTR_CHECK_EN
   instr_result_check u_check (
      .instr_i    (instruction_word),
      .mismatch_o (chk)
   );
`else
   assign chk = 1'b0;
`endif

   assign start_ok = start && (count != 6'd0) && (int'(count) <= DEPTH);
   assign ptr_inc  = (int'(ptr_q) == DEPTH - 1) ? '0 : ptr_q + address_t'(1);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rem_d     = rem_q;
      valid_d   = valid_q;
      mm_d      = mm_q;
      busy_d    = busy_q;
      instr_d   = instr_q;
      out_ptr_d = out_ptr_q;
      err_d     = err_q;
      case (state_q)
         IDLE: if (start_ok) begin
            ptr_d   = first_ptr;
            rem_d   = count - 6'd1;
            busy_d  = 1'b1;
            state_d = FETCH;
         end
         FETCH: begin
            instr_d   = instruction_word;
            out_ptr_d = ptr_q;
            mm_d      = chk;
            valid_d   = 1'b1;
            err_d     = (chk && err_q != '1) ? err_q + ERR_CNT_W'(1) : err_q;
            state_d   = PRESENT;
         end
         PRESENT: if (out_ready) begin
            valid_d = 1'b0;
            mm_d    = 1'b0;
            if (rem_q == 6'd0) state_d = FINISH;
            else begin
               ptr_d   = ptr_inc;
               rem_d   = rem_q - 6'd1;
               state_d = FETCH;
            end
         end
         FINISH: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         rem_q     <= '0;
         valid_q   <= 1'b0;
         mm_q      <= 1'b0;
         busy_q    <= 1'b0;
         instr_q   <= INSTR_RESET;
         out_ptr_q <= '0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rem_q     <= rem_d;
         valid_q   <= valid_d;
         mm_q      <= mm_d;
         busy_q    <= busy_d;
         instr_q   <= instr_d;
         out_ptr_q <= out_ptr_d;
         err_q     <= err_d;
      end
   end

   assign read_pointer = ptr_q;
   assign out_valid    = valid_q;
   assign out_instr    = instr_q;
   assign out_ptr      = out_ptr_q;
   assign mismatch     = mm_q;
   assign busy         = busy_q;
   assign done         = (state_q == FINISH);
   assign err_count    = err_q;

endmodule

// File: tb/tb_instr_read_seq.sv
// tb_instr_read_seq: scoreboard bench for instr_read_seq with directed register contents.
module tb_instr_read_seq;
   import instr_register_pkg::*;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic         out_ready = 1'b0;
   address_t     first_ptr = '0;
   logic [5:0]   count = '0;
   instruction_t instruction_word;
   instruction_t out_instr;
   address_t     read_pointer;
   address_t     out_ptr;
   logic         out_valid;
   logic         mismatch;
   logic         busy;
   logic         done;
   logic [5:0]   err_count;

   instruction_t mem [32];
   int checks = 0;
   int failures = 0;

`ifdef INSTR_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   typedef struct {
      address_t     ptr;
      instruction_t ins;
      logic         mm;
   } exp_t;
   exp_t sb[$];

   instr_read_seq dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .first_ptr        (first_ptr),
      .count            (count),
      .instruction_word (instruction_word),
      .read_pointer     (read_pointer),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_instr        (out_instr),
      .out_ptr          (out_ptr),
      .mismatch         (mismatch),
      .busy             (busy),
      .done             (done),
      .err_count        (err_count)
   );

   always #5 clk = ~clk;
   assign instruction_word = mem[read_pointer];

   task automatic check(string name, logic [135:0] act, logic [135:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic instruction_t mk(opcode_t o, int a, int b, longint r);
      return '{opc: o, op_a: a, op_b: b, res: r};
   endfunction

   task automatic push(address_t p, logic m);
      sb.push_back('{ptr: p, ins: mem[p], mm: m});
   endtask

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start(address_t p, logic [5:0] c);
      first_ptr = p;
      count = c;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(int max);
      int n = 0;
      while (!out_valid && n < max) begin
         tick();
         n++;
      end
      check("wait_valid", 136'(out_valid), 136'(1));
   endtask

   task automatic wait_done(string tag, int max);
      int n = 0;
      while (!done && n < max) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, 136'(done), 136'(1));
      check({tag, "_all_handshakes"}, 136'(sb.size()), 136'(0));
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 136'(done), 136'(0));
      check({tag, "_busy_cleared"}, 136'(busy), 136'(0));
   endtask

   // Monitor: every accepted output is popped and compared against the scoreboard.
   initial forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
         if (sb.size() == 0) check("unexpected_handshake", 136'(1), 136'(0));
         else begin
            exp_t e;
            e = sb.pop_front();
            check("hs_ptr", 136'(out_ptr), 136'(e.ptr));
            check("hs_instr", 136'(out_instr), 136'(e.ins));
            check("hs_mismatch", 136'(mismatch), 136'(e.mm));
         end
      end
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = mk(ZERO, 0, 0, 0);
      mem[0]  = mk(ADD, 5, 3, 8);
      mem[1]  = mk(SUB, 5, 7, -2);
      mem[2]  = mk(MULT, -4, 6, -24);
      mem[3]  = mk(DIV, 9, 0, 0);
      mem[4]  = mk(ADD, 7, 3, 1);
      mem[5]  = mk(opcode_t'(4'd15), 1, 1, 0);
      mem[6]  = mk(POW, 3, 4, 81);
      mem[7]  = mk(MOD, -7, 3, -1);
      mem[8]  = mk(POW, 2, -1, 0);
      mem[9]  = mk(MOD, 5, 0, 0);
      mem[11] = mk(MULT, 2147483647, 2, 64'sd4294967294);
      mem[30] = mk(PASSA, 11, 22, 11);
      mem[31] = mk(PASSB, -1, -9, -9);

      #1;
      check("rst_read_pointer", 136'(read_pointer), 136'(0));
      check("rst_out_valid", 136'(out_valid), 136'(0));
      check("rst_out_instr", 136'(out_instr), 136'(mk(ZERO, 0, 0, 0)));
      check("rst_out_ptr", 136'(out_ptr), 136'(0));
      check("rst_busy", 136'(busy), 136'(0));
      check("rst_done", 136'(done), 136'(0));
      check("rst_err_count", 136'(err_count), 136'(0));
      #11 reset_n = 1'b1;

      // Four correct entries at full throughput.
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(address_t'(i), 1'b0);
      do_start(5'd0, 6'd4);
      check("A_fetch_busy", 136'(busy), 136'(1));
      check("A_fetch_valid", 136'(out_valid), 136'(0));
      tick();
      check("A_present_valid", 136'(out_valid), 136'(1));
      wait_done("A", 40);

      // Pointer wrap 30,31,0,1.
      push(5'd30, 1'b0);
      push(5'd31, 1'b0);
      push(5'd0, 1'b0);
      push(5'd1, 1'b0);
      do_start(5'd30, 6'd4);
      wait_done("B", 40);

      // Back-pressure: hold out_ready low for 5 cycles.
      out_ready = 1'b0;
      push(5'd0, 1'b0);
      push(5'd1, 1'b0);
      do_start(5'd0, 6'd2);
      tick();
      repeat (5) begin
         tick();
         check("C_stall_valid", 136'(out_valid), 136'(1));
         check("C_stall_instr", 136'(out_instr), 136'(mem[0]));
         check("C_stall_ptr", 136'(out_ptr), 136'(0));
         check("C_stall_rdptr", 136'(read_pointer), 136'(0));
      end
      out_ready = 1'b1;
      tick();
      check("C_resume_valid", 136'(out_valid), 136'(0));
      check("C_resume_rdptr", 136'(read_pointer), 136'(1));
      wait_done("C", 40);

      // Mismatching entries, edge-case opcodes, then counter saturation.
      push(5'd4, CHK);
      push(5'd5, CHK);
      for (int i = 6; i < 10; i++) push(address_t'(i), 1'b0);
      do_start(5'd4, 6'd6);
      tick();
      check("D_first_mismatch", 136'(mismatch), 136'(CHK));
      check("D_first_err_count", 136'(err_count), 136'(CHK));
      wait_done("D", 60);
      check("D_err_count_2", 136'(err_count), 136'(CHK ? 2 : 0));
      repeat (34) begin
         push(5'd4, CHK);
         push(5'd5, CHK);
         do_start(5'd4, 6'd2);
         wait_done("D_sat", 20);
      end
      check("D_err_count_sat", 136'(err_count), 136'(CHK ? 63 : 0));

      // Ignored starts: count 0, count above DEPTH, and start while busy.
      out_ready = 1'b0;
      do_start(5'd7, 6'd0);
      check("E_cnt0_busy", 136'(busy), 136'(0));
      check("E_cnt0_rdptr", 136'(read_pointer), 136'(5));
      tick(2);
      check("E_cnt0_idle_valid", 136'(out_valid), 136'(0));
      do_start(5'd7, 6'd33);
      check("E_cnt33_busy", 136'(busy), 136'(0));
      check("E_cnt33_rdptr", 136'(read_pointer), 136'(5));
      push(5'd10, 1'b0);
      push(5'd11, 1'b0);
      do_start(5'd10, 6'd2);
      tick();
      do_start(5'd20, 6'd3);
      check("E_busy_start_busy", 136'(busy), 136'(1));
      check("E_busy_start_rdptr", 136'(read_pointer), 136'(10));
      check("E_busy_start_valid", 136'(out_valid), 136'(1));
      check("E_busy_start_ptr", 136'(out_ptr), 136'(10));
      out_ready = 1'b1;
      wait_done("E", 40);
      tick(4);
      check("E_no_restart", 136'(busy), 136'(0));

      // Asynchronous reset while presenting entry 3 of 5.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(address_t'(i), 1'b0);
      push(5'd4, CHK);
      do_start(5'd0, 6'd5);
      repeat (3) begin
         wait_valid(10);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
      wait_valid(10);
      check("F_at_entry3", 136'(out_ptr), 136'(3));
      #2 reset_n = 1'b0;
      #1;
      check("F_rst_read_pointer", 136'(read_pointer), 136'(0));
      check("F_rst_out_valid", 136'(out_valid), 136'(0));
      check("F_rst_out_instr", 136'(out_instr), 136'(mk(ZERO, 0, 0, 0)));
      check("F_rst_out_ptr", 136'(out_ptr), 136'(0));
      check("F_rst_mismatch", 136'(mismatch), 136'(0));
      check("F_rst_busy", 136'(busy), 136'(0));
      check("F_rst_done", 136'(done), 136'(0));
      check("F_rst_err_count", 136'(err_count), 136'(0));
      sb.delete();
      repeat (3) begin
         @(negedge clk);
         check("F_no_done", 136'(done), 136'(0));
      end
      #2 reset_n = 1'b1;
      tick(3);
      check("F_after_busy", 136'(busy), 136'(0));
      check("F_after_done", 136'(done), 136'(0));
      check("F_after_valid", 136'(out_valid), 136'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_read_seq.md
Name: instr_read_seq

Overview:
Downstream stage of the instruction register. It walks a programmed window of register entries by driving read_pointer and captures each returned instruction_word. Each entry is presented on a valid/ready output stream, and the sequencer recomputes the expected result per opcode and flags mismatches. It feeds the execution/logging stage and the lab self-check.

Parameters:
DEPTH, 32, number of register entries; the pointer wraps modulo DEPTH.
ERR_CNT_W, 6, width of the saturating mismatch counter.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a read sequence
first_ptr  input  address_t  first entry to read
count  input  6  number of entries to read; valid range 1..DEPTH
instruction_word  input  instruction_t  entry returned combinationally by the register for read_pointer
read_pointer  output  address_t  entry currently addressed
out_valid  output  1  out_instr/out_ptr/mismatch are valid
out_ready  input  1  consumer accepts the current output
out_instr  output  instruction_t  captured entry
out_ptr  output  address_t  index the captured entry came from
mismatch  output  1  captured result differs from the recomputed expected result
busy  output  1  sequence in progress
done  output  1  one-cycle pulse after the last handshake
err_count  output  ERR_CNT_W  saturating mismatch count since reset

Behaviour:
- Reset (asynchronous, any state, including mid-sequence): state IDLE.
  - read_pointer=0, out_valid=0, out_instr='{opc:ZERO,default:0}, out_ptr=0.
  - mismatch=0, busy=0, done=0, err_count=0.
- FSM states: IDLE, FETCH, PRESENT, FINISH.
- IDLE:
  - start=1 with 1<=count<=DEPTH: read_pointer<=first_ptr, remaining<=count-1, busy<=1, go to FETCH.
  - start with count=0 or count>DEPTH: ignored, no state change.
- FETCH (one cycle; read_pointer is stable and instruction_word is sampled at the end of the cycle):
  - out_instr<=instruction_word, out_ptr<=read_pointer, mismatch<=check result, out_valid<=1.
  - go to PRESENT.
- PRESENT:
  - Hold all outputs stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready: out_valid<=0 and mismatch<=0.
  - If remaining==0, go to FINISH.
  - Otherwise read_pointer<=(read_pointer+1) mod DEPTH (31 wraps to 0), remaining<=remaining-1, go to FETCH.
- FINISH: done=1 for exactly one cycle, busy<=0, go to IDLE.
- start while busy: ignored.
- Latency and throughput:
  - start edge to out_valid=1 is 2 cycles.
  - Throughput is at most one entry per 2 cycles; out_ready held high gives a handshake every other cycle.
- Expected result, computed in result_t (signed 64) from sign-extended operands:
  - ZERO gives 0; PASSA gives a; PASSB gives b.
  - ADD a+b; SUB a-b; MULT a*b.
  - DIV a/b, with b==0 giving 0.
  - MOD a%b, with b==0 giving 0.
  - POW a**b, with b<0 giving 0.
  - Undefined opcode encoding: mismatch=1.
- err_count increments on each FETCH that produces mismatch=1 and saturates at all-ones.

Optional Feature:
INSTR_CHECK_EN
- Defined: expected-result logic is present; mismatch and err_count behave as above.
- Undefined: no checker logic is instantiated; mismatch and err_count are tied to 0; sequencing and handshake behaviour are identical.

Decomposition:
- instr_register_pkg (shared) holds:
  - operand_t (signed 32), result_t (signed 64), opcode_t enum (ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD, POW).
  - address_t (5 bit), instruction_t {opc, op_a, op_b, res}.
  - new seq_state_t enum.
  - function calc_expected(opcode_t, operand_t, operand_t) returning result_t, shared with the testbench scoreboard.
- Sub-module instr_result_check (combinational: instruction_t in, mismatch out) is instantiated only under INSTR_CHECK_EN.

Test Plan:
- Reset asserted mid-PRESENT at entry 3 of 5 -> all outputs at reset values immediately; busy=0; no done pulse.
- Entries 0..3 loaded with ADD 5,3 / SUB 5,7 / MULT -4,6 / DIV 9,0 (correct results); start first_ptr=0 count=4, out_ready=1 -> 4 handshakes at out_ptr 0,1,2,3; res = 8,-2,-24,0; mismatch=0; done 1 cycle after the 4th.
- first_ptr=30, count=4 -> out_ptr sequence 30,31,0,1; done after the 4th handshake.
- out_ready held 0 for 5 cycles at entry 0 -> out_valid, out_instr and out_ptr stable; read_pointer unchanged; proceeds the cycle after out_ready=1.
- Entry holding ADD 7,3 with res=1 (INSTR_CHECK_EN) -> mismatch=1 and err_count=1; 70 such entries -> err_count saturates at 63; without the macro mismatch=0 and err_count=0.
- start with count=0, then start while busy -> both ignored; busy and read_pointer are unaffected.
